// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage types and constants
package if_stage_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST   = 32'h0000_0013;
    localparam logic [31:0] INST_BYTES = 32'd4;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_stage.sv
// if_stage: PC owner, single-outstanding instruction fetch and IF/ID register
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = if_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_IR,
    output logic [31:0] if_id_PC,
    output logic [31:0] if_id_NPC,
    output logic        if_id_valid_inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, req_pc_q, hold_data_q, hold_pc_q;
    logic         kill_q, hold_valid_q;
    logic         req_fire, rsp_in_wait, rsp_live, load_rsp, load_hold;

    // A response only matters while waiting; it is live unless killed or redirected now.
    assign req_fire    = imem_req_valid && imem_req_ready;
    assign rsp_in_wait = state_q == WAIT && imem_rsp_valid;
    assign rsp_live    = rsp_in_wait && !kill_q && !ex_redirect;
    assign load_rsp    = rsp_live && !id_stall;
    assign load_hold   = state_q == HOLD && hold_valid_q && !id_stall && !ex_redirect;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= REQ;
        else     state_q <= state_d;
    end

    // Next-state: any response (live, killed or redirected) closes the outstanding request
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ:     state_d = req_fire ? WAIT : REQ;
            WAIT:    state_d = !imem_rsp_valid ? WAIT : (rsp_live && id_stall) ? HOLD : REQ;
            HOLD:    state_d = (ex_redirect || !id_stall) ? REQ : HOLD;
            default: state_d = REQ;
        endcase
    end

    // Request outputs: suppressed in reset and on the redirect cycle
    always_comb begin
        imem_req_valid = !rst && state_q == REQ && !ex_redirect;
        imem_addr      = pc_q;
    end

    // PC and the address of the request in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            pc_q     <= ex_redirect ? word_align(ex_target_pc) : req_fire ? pc_q + INST_BYTES : pc_q;
            req_pc_q <= req_fire ? pc_q : req_pc_q;
        end
    end

    // Kill marks the outstanding request stale; its response clears it
    always_ff @(posedge clk) begin
        if (rst)                             kill_q <= 1'b0;
        else if (rsp_in_wait)                kill_q <= 1'b0;
        else if (state_q == WAIT && ex_redirect) kill_q <= 1'b1;
    end

    // Hold buffer parks a response that decode could not take
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= NOP_INST;
            hold_pc_q    <= RESET_PC;
        end else if (rsp_live && id_stall) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= imem_rsp_data;
            hold_pc_q    <= req_pc_q;
        end else if (state_q == HOLD && (ex_redirect || !id_stall)) begin
            hold_valid_q <= 1'b0;
        end
    end

    // IF/ID register: redirect flushes, stall freezes, otherwise load or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_IR         <= NOP_INST;
            if_id_PC         <= 32'd0;
            if_id_NPC        <= INST_BYTES;
            if_id_valid_inst <= 1'b0;
        end else if (ex_redirect || (!id_stall && !load_rsp && !load_hold)) begin
            if_id_IR         <= NOP_INST;
            if_id_valid_inst <= 1'b0;
        end else if (!id_stall) begin
            if_id_IR         <= load_rsp ? imem_rsp_data : hold_data_q;
            if_id_PC         <= load_rsp ? req_pc_q : hold_pc_q;
            if_id_NPC        <= (load_rsp ? req_pc_q : hold_pc_q) + INST_BYTES;
            if_id_valid_inst <= 1'b1;
        end
    end

    // Memory must only respond while a request is outstanding
    assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && state_q != WAIT));

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized and directed checks of if_stage against a transaction-level model
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, id_stall = 1'b0, ex_redirect = 1'b0;
    logic        imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic [31:0] ex_target_pc = 32'd0, imem_rsp_data = 32'd0;
    logic        imem_req_valid, if_id_valid_inst;
    logic [31:0] imem_addr, if_id_IR, if_id_PC, if_id_NPC;

    int checks = 0, failures = 0;
    bit checking = 1'b0;

    // model: fetch bookkeeping expressed as flags, not as an FSM
    logic [31:0] m_pc, m_req_pc, m_buf_data, m_buf_pc, m_ifid_ir, m_ifid_pc, m_ifid_npc;
    bit          m_waiting, m_killed, m_buf_valid, m_ifid_valid;

    // memory: one outstanding request, fixed latency chosen at acceptance
    bit          mb, sv;
    int          mc, mem_lat = 1;
    logic [31:0] ma, sa;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .ex_redirect(ex_redirect),
        .ex_target_pc(ex_target_pc), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_id_IR(if_id_IR), .if_id_PC(if_id_PC), .if_id_NPC(if_id_NPC),
        .if_id_valid_inst(if_id_valid_inst)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit got, issue, deliver;
        logic [31:0] d_ir, d_pc;
        deliver = 1'b0;
        d_ir = 32'd0;
        d_pc = 32'd0;
        if (rst) begin
            m_pc = 32'd0; m_req_pc = 32'd0;
            m_waiting = 1'b0; m_killed = 1'b0; m_buf_valid = 1'b0;
            m_ifid_valid = 1'b0; m_ifid_ir = NOP_INST; m_ifid_pc = 32'd0; m_ifid_npc = 32'd4;
            return;
        end
        got = m_waiting && imem_rsp_valid;
        if (ex_redirect) begin
            m_pc = ex_target_pc & ~32'd3;
            m_ifid_valid = 1'b0;
            m_ifid_ir = NOP_INST;
            m_buf_valid = 1'b0;
            if (got) begin
                m_waiting = 1'b0;
                m_killed = 1'b0;
            end else if (m_waiting) begin
                m_killed = 1'b1;
            end
            return;
        end
        issue = !m_waiting && !m_buf_valid && imem_req_ready;
        if (got) begin
            m_waiting = 1'b0;
            if (m_killed) m_killed = 1'b0;
            else if (id_stall) begin
                m_buf_valid = 1'b1; m_buf_data = imem_rsp_data; m_buf_pc = m_req_pc;
            end else begin
                deliver = 1'b1; d_ir = imem_rsp_data; d_pc = m_req_pc;
            end
        end else if (m_buf_valid && !id_stall) begin
            deliver = 1'b1; d_ir = m_buf_data; d_pc = m_buf_pc; m_buf_valid = 1'b0;
        end
        if (issue) begin
            m_req_pc = m_pc;
            m_pc = m_pc + 32'd4;
            m_waiting = 1'b1;
        end
        if (!id_stall) begin
            m_ifid_valid = deliver;
            m_ifid_ir = deliver ? d_ir : NOP_INST;
            if (deliver) begin
                m_ifid_pc = d_pc;
                m_ifid_npc = d_pc + 32'd4;
            end
        end
    endtask

    task automatic mem_step();
        if (rst) begin
            mb = 1'b0;
            return;
        end
        if (imem_rsp_valid) mb = 1'b0;
        if (sv && imem_req_ready) begin
            mb = 1'b1; ma = sa; mc = mem_lat - 1;
        end else if (mb && mc > 0) begin
            mc--;
        end
    endtask

    // one cycle: sample request, advance model and memory at the edge, drive next inputs
    task automatic tick(input bit r, input bit st, input bit rd, input logic [31:0] tgt, input bit rdy);
        @(negedge clk);
        sv = imem_req_valid;
        sa = imem_addr;
        @(posedge clk);
        model_step();
        mem_step();
        #1;
        rst = r; id_stall = st; ex_redirect = rd; ex_target_pc = tgt; imem_req_ready = rdy;
        imem_rsp_valid = mb && mc == 0;
        imem_rsp_data = (mb && mc == 0) ? mem_fn(ma) : 32'hDEAD_BEEF;
        checking = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("req_valid", 32'(imem_req_valid), 32'(!rst && !m_waiting && !m_buf_valid && !ex_redirect));
            if (!rst && !m_waiting && !m_buf_valid && !ex_redirect) chk("imem_addr", imem_addr, m_pc);
            chk("if_id_valid", 32'(if_id_valid_inst), 32'(m_ifid_valid));
            chk("if_id_IR", if_id_IR, m_ifid_ir);
            if (m_ifid_valid) begin
                chk("if_id_PC", if_id_PC, m_ifid_pc);
                chk("if_id_NPC", if_id_NPC, m_ifid_npc);
                chk("IR_matches_mem", if_id_IR, mem_fn(if_id_PC));
            end
        end
    end

    initial begin
        // reset release with a 1-cycle memory, no stall
        mem_lat = 1;
        tick(1, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 1);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_valid", 32'(if_id_valid_inst), 32'd0);
        chk("rst_IR", if_id_IR, 32'h0000_0013);
        chk("rst_PC", if_id_PC, 32'd0);
        chk("rst_NPC", if_id_NPC, 32'd4);
        tick(0, 0, 0, 0, 1);
        chk("s1_addr0", imem_addr, 32'd0);
        chk("s1_rv0", 32'(imem_req_valid), 32'd1);
        tick(0, 0, 0, 0, 1);
        chk("s1_wait_rv", 32'(imem_req_valid), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("s1_pc0", if_id_PC, 32'd0);
        chk("s1_npc0", if_id_NPC, 32'd4);
        chk("s1_v0", 32'(if_id_valid_inst), 32'd1);
        chk("s1_addr4", imem_addr, 32'd4);
        tick(0, 0, 0, 0, 1);
        chk("s1_bubble", 32'(if_id_valid_inst), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("s1_pc4", if_id_PC, 32'd4);
        chk("s1_addr8", imem_addr, 32'd8);
        // stall for three cycles while the response for PC 8 arrives
        tick(0, 1, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        chk("s2_hold_rv", 32'(imem_req_valid), 32'd0);
        chk("s2_frozen", 32'(if_id_valid_inst), 32'd0);
        tick(0, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("s2_hold_rv2", 32'(imem_req_valid), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("s2_pc8", if_id_PC, 32'd8);
        chk("s2_v8", 32'(if_id_valid_inst), 32'd1);
        chk("s2_addr12", imem_addr, 32'd12);
        // redirect to 0x100 while waiting on 0x10 with a 3-cycle memory
        mem_lat = 3;
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 1, 32'h10, 1);
        chk("s3_redir_req", 32'(imem_req_valid), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("s3_addr10", imem_addr, 32'h10);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 1, 32'h100, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("s3_dropped", 32'(if_id_valid_inst), 32'd0);
        chk("s3_addr100", imem_addr, 32'h100);
        repeat (4) tick(0, 0, 0, 0, 1);
        chk("s3_pc100", if_id_PC, 32'h100);
        chk("s3_v100", 32'(if_id_valid_inst), 32'd1);
        // redirect and stall together while IF/ID holds 0x20
        mem_lat = 1;
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 1, 32'h20, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        tick(0, 1, 1, 32'h44, 1);
        chk("s4_pc20", if_id_PC, 32'h20);
        tick(0, 0, 0, 0, 1);
        chk("s4_flush_v", 32'(if_id_valid_inst), 32'd0);
        chk("s4_flush_IR", if_id_IR, 32'h0000_0013);
        chk("s4_addr44", imem_addr, 32'h44);
        // wrap from 0xFFFF_FFFC; low target bits are ignored
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 1, 32'hFFFF_FFFF, 1);
        tick(0, 0, 0, 0, 1);
        chk("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        chk("s5_pc_top", if_id_PC, 32'hFFFF_FFFC);
        chk("s5_npc_wrap", if_id_NPC, 32'd0);
        chk("s5_addr_wrap", imem_addr, 32'd0);
        // ready low in REQ, then a reset pulse
        tick(1, 0, 0, 0, 1);
        tick(0, 0, 1, 32'h80, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 0);
            chk("s6_addr_stable", imem_addr, 32'h80);
        end
        tick(1, 0, 0, 0, 0);
        chk("s6_rst_rv", 32'(imem_req_valid), 32'd0);
        tick(0, 0, 0, 0, 1);
        chk("s6_addr_reset", imem_addr, 32'd0);
        chk("s6_IR_reset", if_id_IR, 32'h0000_0013);
        chk("s6_NPC_reset", if_id_NPC, 32'd4);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            mem_lat = $urandom_range(1, 3);
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom),
                 $urandom_range(0, 3) != 0);
        end
        tick(0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
